// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Purpose:
//   Radix-2 shift-and-add multiplier. It works on operand magnitudes and
//   applies the sign once at the end, so signed and unsigned operands share
//   a single unsigned datapath. One multiplier bit is processed per clock.
//   A result is ready WIDTH+1 edges after the edge that samples start.
//
// Ports:
//   clk        single clock; all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   start      request a multiply; only honoured in IDLE
//   is_signed  1 = A/B are two's complement, 0 = unsigned
//   A          multiplicand, WIDTH bits
//   B          multiplier, WIDTH bits
//   busy       high while the operation is in CALC or SIGN
//   done       one-cycle pulse; P holds a new result
//   P          product, 2*WIDTH bits, held until the next result or reset
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t r_state;
    state_t w_nextState;

    // Operation context captured at start
    logic               r_isSigned;
    logic               r_signA;
    logic               r_signB;
    logic [WIDTH-1:0]   r_magA;

    // {r_acc, r_mult} is the shifting accumulator/multiplier pair
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mult;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_magProduct;
    logic               w_negate;
    logic [2*WIDTH-1:0] w_finalProduct;

    // Operand conditioning. Negating the most negative value wraps back to
    // the same bit pattern, which read as unsigned is exactly 2^(WIDTH-1),
    // so no extra bit is needed for the magnitude.
    assign w_load  = (r_state == IDLE) && start;
    assign w_signA = is_signed & A[WIDTH-1];
    assign w_signB = is_signed & B[WIDTH-1];
    assign w_magA  = w_signA ? (~A + WIDTH'(1)) : A;
    assign w_magB  = w_signB ? (~B + WIDTH'(1)) : B;

    // One shift-add step. The extra top bit of w_sum is the carry that is
    // shifted back into the accumulator MSB.
    assign w_sum = {1'b0, r_acc} + (r_mult[0] ? {1'b0, r_magA} : {(WIDTH+1){1'b0}});

    // Sign fix-up. A zero magnitude negates to zero, so there is no
    // negative zero to special-case.
    assign w_magProduct   = {r_acc, r_mult};
    assign w_negate       = r_isSigned & (r_signA ^ r_signB);
    assign w_finalProduct = w_negate ? (~w_magProduct + (2*WIDTH)'(1)) : w_magProduct;

    assign P = r_product;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode; start is only looked at in IDLE
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_count == LAST_STEP) begin
                    w_nextState = SIGN;
                end
            end
            SIGN: begin
                busy        = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture, iterate and sign-correct datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isSigned <= 1'b0;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_magA     <= '0;
            r_acc      <= '0;
            r_mult     <= '0;
            r_count    <= '0;
            r_product  <= '0;
        end else begin
            if (w_load) begin
                r_isSigned <= is_signed;
                r_signA    <= w_signA;
                r_signB    <= w_signB;
                r_magA     <= w_magA;
                r_mult     <= w_magB;
                r_acc      <= '0;
                r_count    <= '0;
            end else if (r_state == CALC) begin
                r_acc   <= w_sum[WIDTH:1];
                r_mult  <= {w_sum[0], r_mult[WIDTH-1:1]};
                r_count <= r_count + CW'(1);
            end else if (r_state == SIGN) begin
                r_product <= w_finalProduct;
            end
        end
    end

endmodule
